// File: rtl/dbg_core_resp_pkg.sv
// Shared encodings for the core-side debug access responder: operation codes,
// FSM state encoding and small op-decoding helpers.
package dbg_core_resp_pkg;

    typedef enum logic [1:0] {
        DbgOpRegRd = 2'd0,
        DbgOpRegWr = 2'd1,
        DbgOpMemRd = 2'd2,
        DbgOpMemWr = 2'd3
    } dbg_op_e;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StReg     = 3'd1,
        StMemReq  = 3'd2,
        StMemWait = 3'd3,
        StAck     = 3'd4
    } dbg_state_e;

    // Bit 1 of the op selects the bus, bit 0 selects write.
    function automatic logic op_is_mem(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_write(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous level inputs,
// cleared by a synchronous active-low reset.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_d;
    logic [WIDTH-1:0] sync_q;

    // Next-state of the two synchronizer stages.
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    // Synchronizer flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= {WIDTH{1'b0}};
            sync_q <= {WIDTH{1'b0}};
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dbg_core_resp.sv
// Core-clock responder for debug-module requests: synchronizes the 4-phase
// request, performs the GPR or bus access and returns data, error and ack.
module dbg_core_resp
    import dbg_core_resp_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dbg_req_i,
    input  logic [1:0]  dbg_op_i,
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic        dbg_ack_o,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_err_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_addr_o,
    output logic [31:0] reg_wdata_o,
    input  logic [31:0] reg_rdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        halt_req_i,
    input  logic        reset_req_i,
    output logic        halt_req_o,
    output logic        reset_req_o
);

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] CNT_MAX  = TO_W'(TIMEOUT);

    logic req_s;
    logic halt_s;
    logic reset_s;

    sync2 #(
        .WIDTH(3)
    ) u_sync2 (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  ({dbg_req_i, halt_req_i, reset_req_i}),
        .q_o  ({req_s, halt_s, reset_s})
    );

    dbg_state_e        state_d,     state_q;
    logic [1:0]        op_d,        op_q;
    logic [TO_W-1:0]   cnt_d,       cnt_q;
    logic              ack_d,       ack_q;
    logic [31:0]       rdata_d,     rdata_q;
    logic              err_d,       err_q;
    logic              reg_we_d,    reg_we_q;
    logic [4:0]        reg_addr_d,  reg_addr_q;
    logic [31:0]       reg_wdata_d, reg_wdata_q;
    logic              mem_req_d,   mem_req_q;
    logic              mem_we_d,    mem_we_q;
    logic [31:0]       mem_addr_d,  mem_addr_q;
    logic [31:0]       mem_wdata_d, mem_wdata_q;

    logic              timeout_s;
    logic [TO_W-1:0]   cnt_inc_s;

    // Timeout detection; the counter saturates so a late grant cannot wrap it.
    always_comb begin
        timeout_s = (cnt_q >= CNT_LAST);
        if (cnt_q == CNT_MAX) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + TO_W'(1);
        end
    end

    // FSM next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        ack_d       = ack_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        reg_we_d    = 1'b0;
        reg_addr_d  = 5'd0;
        reg_wdata_d = 32'd0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            StIdle: begin
                ack_d = 1'b0;
                if (req_s) begin
                    op_d  = dbg_op_i;
                    err_d = 1'b0;
                    if (op_is_mem(dbg_op_i)) begin
                        state_d     = StMemReq;
                        cnt_d       = {TO_W{1'b0}};
                        mem_req_d   = 1'b1;
                        mem_we_d    = op_is_write(dbg_op_i);
                        mem_addr_d  = dbg_addr_i;
                        mem_wdata_d = dbg_wdata_i;
                    end else begin
                        state_d    = StReg;
                        reg_addr_d = dbg_addr_i[4:0];
                        reg_we_d   = op_is_write(dbg_op_i);
                        if (op_is_write(dbg_op_i)) begin
                            reg_wdata_d = dbg_wdata_i;
                        end else begin
                            reg_wdata_d = 32'd0;
                        end
                    end
                end else begin
                    state_d = StIdle;
                end
            end

            // reg_addr_o is live this cycle, so the combinational GPR read is valid.
            StReg: begin
                if (!op_is_write(op_q)) begin
                    rdata_d = reg_rdata_i;
                end else begin
                    rdata_d = rdata_q;
                end
                state_d = StAck;
                ack_d   = 1'b1;
            end

            StMemReq: begin
                cnt_d = cnt_inc_s;
                if (mem_gnt_i) begin
                    state_d     = StMemWait;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'd0;
                    mem_wdata_d = 32'd0;
                end else if (timeout_s) begin
                    state_d     = StAck;
                    ack_d       = 1'b1;
                    err_d       = 1'b1;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'd0;
                    mem_wdata_d = 32'd0;
                end else begin
                    state_d = StMemReq;
                end
            end

            StMemWait: begin
                cnt_d = cnt_inc_s;
                if (mem_rvalid_i) begin
                    if (!op_is_write(op_q)) begin
                        rdata_d = mem_rdata_i;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d = StAck;
                    ack_d   = 1'b1;
                end else if (timeout_s) begin
                    state_d = StAck;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = StMemWait;
                end
            end

            StAck: begin
                if (!req_s) begin
                    state_d = StIdle;
                    ack_d   = 1'b0;
                end else begin
                    state_d = StAck;
                    ack_d   = 1'b1;
                end
            end

            default: begin
                state_d     = StIdle;
                ack_d       = 1'b0;
                err_d       = 1'b0;
                mem_req_d   = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = 32'd0;
                mem_wdata_d = 32'd0;
            end
        endcase
    end

    // State and output registers; reset abandons any pending bus request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= 2'd0;
            cnt_q       <= {TO_W{1'b0}};
            ack_q       <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= 5'd0;
            reg_wdata_q <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            reg_we_q    <= reg_we_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign dbg_ack_o   = ack_q;
    assign dbg_rdata_o = rdata_q;
    assign dbg_err_o   = err_q;
    assign reg_we_o    = reg_we_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign halt_req_o  = halt_s;
    assign reset_req_o = reset_s;

endmodule

// File: tb/tb_dbg_core_resp.sv
// Self-checking bench for dbg_core_resp: directed table, random transactions
// against a cycle-count reference model, and reset / synchronizer sequences.
module tb_dbg_core_resp;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dbg_req_i;
    logic [1:0]  dbg_op_i;
    logic [31:0] dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_ack_o;
    logic [31:0] dbg_rdata_o;
    logic        dbg_err_o;
    logic        reg_we_o;
    logic [4:0]  reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic [31:0] reg_rdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        halt_req_i;
    logic        reset_req_i;
    logic        halt_req_o;
    logic        reset_req_o;

    logic [31:0] rf [32];
    assign reg_rdata_i = rf[reg_addr_o];

    always #5 clk = ~clk;

    dbg_core_resp #(.TIMEOUT(T), .TO_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .dbg_req_i(dbg_req_i), .dbg_op_i(dbg_op_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o),
        .dbg_err_o(dbg_err_o), .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o),
        .reg_wdata_o(reg_wdata_o), .reg_rdata_i(reg_rdata_i), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .halt_req_i(halt_req_i), .reset_req_i(reset_req_i),
        .halt_req_o(halt_req_o), .reset_req_o(reset_req_o)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          g;          // bus cycle (0-based) in which gnt is given
        int          r;          // cycles from gnt to rvalid
        logic [31:0] bus_rd;
        logic [31:0] reg_rd;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;    // negedges from req rise to ack seen
        int          exp_mem;    // cycles mem_req_o is high
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] rd_m;
    vec_t        tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input int g, input int r,
                                input logic [31:0] bus_rd, input logic [31:0] reg_rd,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int exp_lat, input int exp_mem);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.g = g; v.r = r;
        v.bus_rd = bus_rd; v.reg_rd = reg_rd; v.exp_rdata = exp_rdata;
        v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_mem = exp_mem;
        return v;
    endfunction

    // Reference: the bus access has a deadline at cycle T-1; a phase that only
    // starts after the deadline still gets its one cycle to complete.
    function automatic void model_mem(input int g, input int r, output logic err,
                                      output int done);
        int dl;
        if (g > T - 1) begin
            err  = 1'b1;
            done = T - 1;
        end else begin
            dl = (g + 1 > T - 1) ? g + 1 : T - 1;
            if (g + r <= dl) begin
                err  = 1'b0;
                done = g + r;
            end else begin
                err  = 1'b1;
                done = dl;
            end
        end
    endfunction

    task automatic chk_zero(input string nm);
        chk({nm, " ctl"}, 32'({dbg_ack_o, dbg_err_o, reg_we_o, mem_req_o, mem_we_o,
                               halt_req_o, reset_req_o}), 32'd0);
        chk({nm, " rdata"}, dbg_rdata_o, 32'd0);
        chk({nm, " reg"}, 32'(reg_addr_o) | reg_wdata_o, 32'd0);
        chk({nm, " maddr"}, mem_addr_o, 32'd0);
        chk({nm, " mwdata"}, mem_wdata_o, 32'd0);
    endtask

    task automatic do_txn(input int idx, input vec_t v);
        int          m = -1, gnt_at = -1, lat = -1, mem_cyc = 0, we_cnt = 0, drop = -1;
        logic        bus_bad = 1'b0;
        logic        got_err = 1'b0;
        logic [31:0] got_rd = 32'd0, rec_addr = 32'd0, rec_wd = 32'd0;
        string       p;
        p = $sformatf("v%0d", idx);
        for (int i = 0; i < 32; i++) rf[i] = 32'h0F0F_0000 | 32'(i);
        rf[v.addr[4:0]] = v.reg_rd;
        @(negedge clk);
        dbg_op_i = v.op; dbg_addr_i = v.addr; dbg_wdata_i = v.wdata; dbg_req_i = 1'b1;
        for (int c = 1; c <= 100 && lat < 0; c++) begin
            @(negedge clk);
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0BAD_0BAD;
            if (mem_req_o && m < 0) m = 0;
            if (mem_req_o) begin
                mem_cyc++;
                if (mem_we_o !== v.op[0] || mem_addr_o !== v.addr || mem_wdata_o !== v.wdata)
                    bus_bad = 1'b1;
                if (m == v.g) begin
                    mem_gnt_i = 1'b1;
                    gnt_at = m;
                end
            end
            if (gnt_at >= 0 && m == gnt_at + v.r) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i = v.bus_rd;
            end
            if (m >= 0) m++;
            if (reg_we_o) begin
                we_cnt++;
                rec_wd = reg_wdata_o;
            end
            if (reg_addr_o != 5'd0) rec_addr = 32'(reg_addr_o);
            if (dbg_ack_o) begin
                lat = c;
                got_rd = dbg_rdata_o;
                got_err = dbg_err_o;
            end
        end
        chk({p, " ack latency"}, lat, v.exp_lat);
        chk({p, " rdata"}, got_rd, v.exp_rdata);
        chk({p, " err"}, 32'(got_err), 32'(v.exp_err));
        chk({p, " mem_req cycles"}, mem_cyc, v.exp_mem);
        chk({p, " reg_we pulses"}, we_cnt, (v.op == 2'd1) ? 1 : 0);
        chk({p, " reg_addr"}, rec_addr, v.op[1] ? 32'd0 : 32'(v.addr[4:0]));
        if (v.op == 2'd1) chk({p, " reg_wdata"}, rec_wd, v.wdata);
        if (v.op[1]) chk({p, " bus fields"}, 32'(bus_bad), 32'd0);
        // A stray rvalid while acknowledging must not disturb the held result.
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_0000;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        chk({p, " ack hold"}, 32'({dbg_ack_o, dbg_err_o, mem_req_o, reg_we_o}),
            32'({1'b1, v.exp_err, 1'b0, 1'b0}));
        chk({p, " rdata hold"}, dbg_rdata_o, v.exp_rdata);
        dbg_req_i = 1'b0;
        for (int k = 1; k <= 10 && drop < 0; k++) begin
            @(negedge clk);
            if (!dbg_ack_o) drop = k;
        end
        chk({p, " ack fall latency"}, drop, 3);
    endtask

    initial begin
        vec_t        v;
        logic        e;
        int          done;
        int          found;

        rst_n = 1'b0; dbg_req_i = 1'b0; dbg_op_i = 2'd0; dbg_addr_i = 32'd0;
        dbg_wdata_i = 32'd0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        mem_rdata_i = 32'd0; halt_req_i = 1'b0; reset_req_i = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        tbl[0] = mk(2'd1, 32'd5,          32'hDEADBEEF, 0,  0, 32'h0,        32'h13579BDF, 32'h0,        1'b0, 4,  0);
        tbl[1] = mk(2'd0, 32'd3,          32'h0,        0,  0, 32'h0,        32'h12345678, 32'h12345678, 1'b0, 4,  0);
        tbl[2] = mk(2'd2, 32'h0000_1000, 32'h0,        2,  2, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 1'b0, 8,  3);
        tbl[3] = mk(2'd3, 32'h0000_2004, 32'hA5A5A5A5, 0,  1, 32'h11111111, 32'h0,        32'hCAFEF00D, 1'b0, 5,  1);
        tbl[4] = mk(2'd2, 32'h0000_3000, 32'h0,        99, 1, 32'h22222222, 32'h0,        32'hCAFEF00D, 1'b1, 11, 8);
        tbl[5] = mk(2'd2, 32'h0000_3004, 32'h0,        0,  1, 32'h0BADBEEF, 32'h0,        32'h0BADBEEF, 1'b0, 5,  1);
        tbl[6] = mk(2'd2, 32'h0000_4000, 32'h0,        7,  1, 32'h5555AAAA, 32'h0,        32'h5555AAAA, 1'b0, 12, 8);
        tbl[7] = mk(2'd2, 32'h0000_4004, 32'h0,        2,  5, 32'h76543210, 32'h0,        32'h76543210, 1'b0, 11, 3);
        tbl[8] = mk(2'd3, 32'h0000_4008, 32'h0F0F0F0F, 2,  6, 32'h33333333, 32'h0,        32'h76543210, 1'b1, 11, 3);
        tbl[9] = mk(2'd0, 32'hFFFF_FFFF, 32'h0,        0,  0, 32'h0,        32'hA0A0A0A0, 32'hA0A0A0A0, 1'b0, 4,  0);
        for (int i = 0; i < 10; i++) do_txn(i, tbl[i]);

        // Reset while the FSM waits for rvalid.
        halt_req_i = 1'b1; reset_req_i = 1'b1;
        @(negedge clk);
        dbg_op_i = 2'd2; dbg_addr_i = 32'h0000_5000; dbg_req_i = 1'b1;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clk);
            if (mem_req_o) begin
                mem_gnt_i = 1'b1;
                found = 1;
            end
        end
        @(negedge clk);
        mem_gnt_i = 1'b0;
        chk("midop wait", 32'({found[0], mem_req_o, dbg_ack_o, halt_req_o}), 32'b1001);
        rst_n = 1'b0; dbg_req_i = 1'b0; halt_req_i = 1'b0; reset_req_i = 1'b0;
        @(negedge clk);
        chk_zero("reset midop");
        rst_n = 1'b1;
        rd_m = 32'd0;

        @(negedge clk);
        halt_req_i = 1'b1;
        @(negedge clk);
        chk("halt lag1", 32'(halt_req_o), 32'd0);
        @(negedge clk);
        chk("halt lag2", 32'(halt_req_o), 32'd1);
        halt_req_i = 1'b0; reset_req_i = 1'b1;
        @(negedge clk);
        chk("sync lag1", 32'({halt_req_o, reset_req_o}), 32'b10);
        @(negedge clk);
        chk("sync lag2", 32'({halt_req_o, reset_req_o}), 32'b01);
        reset_req_i = 1'b0;

        do_txn(10, mk(2'd2, 32'h0000_6000, 32'h0, 0, 1, 32'h600DCAFE, 32'h0,
                      32'h600DCAFE, 1'b0, 5, 1));
        rd_m = 32'h600DCAFE;

        for (int i = 0; i < 24; i++) begin
            v.op = 2'($urandom_range(0, 3));
            v.addr = $urandom; v.wdata = $urandom;
            v.g = $urandom_range(0, 9); v.r = $urandom_range(1, 9);
            v.bus_rd = $urandom; v.reg_rd = $urandom;
            if (!v.op[1]) begin
                v.exp_err = 1'b0; v.exp_lat = 4; v.exp_mem = 0;
                v.exp_rdata = (v.op == 2'd0) ? v.reg_rd : rd_m;
            end else begin
                model_mem(v.g, v.r, e, done);
                v.exp_err = e; v.exp_lat = 4 + done;
                v.exp_mem = (v.g > T - 1) ? T : v.g + 1;
                v.exp_rdata = (!e && v.op == 2'd2) ? v.bus_rd : rd_m;
            end
            do_txn(100 + i, v);
            rd_m = v.exp_rdata;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
